// File: rtl/mem_arbiter.sv
// Two-master memory arbiter/sequencer: CPU and secondary master share one synchronous memory.
// Define MEM_ARB_RR_EN for round-robin contention handling; otherwise the CPU has fixed priority.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        dev_req,
  input  logic        dev_we,
  input  logic [31:0] dev_addr,
  input  logic [31:0] dev_wdata,
  output logic        dev_ready,
  output logic [31:0] dev_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        grant_dev;
  logic        any_req;
  logic        last_wait;

  assign any_req   = cpu_req | dev_req;
  assign last_wait = (state == WAIT) && (cnt <= 4'd1);
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

`ifdef MEM_ARB_RR_EN
  logic last_dev;

  // On contention the master that was not served last wins.
  always_comb begin
    grant_dev = dev_req && (!cpu_req || !last_dev);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_dev <= 1'b1;
    end else if (state == DONE) begin
      last_dev <= owner;
    end
  end
`else
  always_comb begin
    grant_dev = dev_req && !cpu_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    cpu_ready  = 1'b0;
    dev_ready  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = cmd_we;
        cnt_next   = 4'(MEM_LAT);
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        // A zero count cannot occur normally; leaving on it avoids a stuck FSM.
        if (cnt <= 4'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        cpu_ready  = !owner;
        dev_ready  = owner;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command registers are only loaded in IDLE, isolating the memory from master inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_we    <= 1'b0;
      cmd_addr  <= 32'd0;
      cmd_wdata <= 32'd0;
      owner     <= 1'b0;
    end else if (state == IDLE && any_req) begin
      owner     <= grant_dev;
      cmd_we    <= grant_dev ? dev_we    : cpu_we;
      cmd_addr  <= grant_dev ? dev_addr  : cpu_addr;
      cmd_wdata <= grant_dev ? dev_wdata : cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rdata <= 32'd0;
      dev_rdata <= 32'd0;
    end else if (last_wait && !cmd_we) begin
      if (owner) begin
        dev_rdata <= mem_rdata;
      end else begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule
